// File: rtl/mem_write_buffer.sv
// mem_write_buffer: posted write-back buffer between the dcache memory port and
// Data_Memory. Write-backs are acknowledged after one cycle and drained in order.
// Reads are forwarded from buffered lines, or sent to memory ahead of queued drains.
module mem_write_buffer #(
   parameter int DEPTH  = 4,
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32,
   parameter int OFF_W  = 5
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [ADDR_W-1:0]          addr_i,
   input  logic [LINE_W-1:0]          data_i,
   input  logic                       enable_i,
   input  logic                       write_i,
   output logic                       ack_o,
   output logic [LINE_W-1:0]          data_o,
   output logic [ADDR_W-1:0]          mem_addr_o,
   output logic [LINE_W-1:0]          mem_data_o,
   output logic                       mem_enable_o,
   output logic                       mem_write_o,
   input  logic                       mem_ack_i,
   input  logic [LINE_W-1:0]          mem_data_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       empty_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int LA_W  = ADDR_W - OFF_W;

   localparam logic [1:0] U_IDLE  = 2'd0;
   localparam logic [1:0] U_RD    = 2'd1;
   localparam logic [1:0] U_ACK   = 2'd2;
   localparam logic [1:0] D_IDLE  = 2'd0;
   localparam logic [1:0] D_DRAIN = 2'd1;
   localparam logic [1:0] D_READ  = 2'd2;

   logic [1:0]        ustate;
   logic [1:0]        dstate;
   logic [DEPTH-1:0]  ent_valid;
   logic [LA_W-1:0]   ent_line [DEPTH];
   logic [LINE_W-1:0] ent_data [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;
   logic [LA_W-1:0]   rd_line;

   logic [LA_W-1:0]   req_line;
   logic              rd_hit;
   logic              wr_hit;
   logic [PTR_W-1:0]  rd_idx;
   logic [PTR_W-1:0]  wr_idx;
   logic              full;
   logic              drain_start;
   logic              head_busy;
   logic              drain_done;
   logic              read_done;
   logic              do_enq;
   logic              do_coal;
   logic              unused_off;

   // Offset bits carry no meaning at line granularity.
   assign unused_off  = ^addr_i[OFF_W-1:0];
   assign req_line    = addr_i[ADDR_W-1:OFF_W];
   assign full        = (count == CNT_W'(DEPTH));
   // A drain launched this edge latches head data now, so the head counts as
   // in flight already; coalescing onto it would lose the new data.
   assign drain_start = (dstate == D_IDLE) && (ustate != U_RD) && (count != '0);
   assign head_busy   = (dstate == D_DRAIN) || drain_start;
   assign drain_done  = (dstate == D_DRAIN) && mem_ack_i;
   assign read_done   = (dstate == D_READ) && mem_ack_i;
   assign do_coal     = (ustate == U_IDLE) && enable_i && write_i && wr_hit;
   assign do_enq      = (ustate == U_IDLE) && enable_i && write_i && !wr_hit && !full;
   assign count_o     = count;
   assign empty_o     = (count == '0) && (dstate == D_IDLE);

   // Search entries oldest to youngest so the last hit is the youngest match.
   always_comb begin
      rd_hit = 1'b0;
      wr_hit = 1'b0;
      rd_idx = '0;
      wr_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid[head + PTR_W'(i)] && (ent_line[head + PTR_W'(i)] == req_line)) begin
            rd_hit = 1'b1;
            rd_idx = head + PTR_W'(i);
            if (!((i == 0) && head_busy)) begin
               wr_hit = 1'b1;
               wr_idx = head + PTR_W'(i);
            end
         end
      end
   end

   // FIFO control: valid bits, head/tail pointers and occupancy count.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ent_valid <= '0;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
      end else begin
         if (do_enq) begin
            ent_valid[tail] <= 1'b1;
            tail            <= tail + PTR_W'(1);
         end
         if (drain_done) begin
            ent_valid[head] <= 1'b0;
            head            <= head + PTR_W'(1);
         end
         if (do_enq && !drain_done) begin
            count <= count + CNT_W'(1);
         end else if (!do_enq && drain_done) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Entry payload: written on enqueue or overwritten on coalesce.
   always_ff @(posedge clk_i) begin
      if (do_enq) begin
         ent_line[tail] <= req_line;
         ent_data[tail] <= data_i;
      end else if (do_coal) begin
         ent_data[wr_idx] <= data_i;
      end
   end

   // Upstream FSM: accepts dcache requests and produces the one-cycle ack.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ustate  <= U_IDLE;
         ack_o   <= 1'b0;
         data_o  <= '0;
         rd_line <= '0;
      end else begin
         ack_o <= 1'b0;
         case (ustate)
            U_IDLE: begin
               if (enable_i) begin
                  if (write_i) begin
                     if (wr_hit || !full) begin
                        ustate <= U_ACK;
                        ack_o  <= 1'b1;
                     end
                  end else if (rd_hit) begin
                     data_o <= ent_data[rd_idx];
                     ustate <= U_ACK;
                     ack_o  <= 1'b1;
                  end else begin
                     rd_line <= req_line;
                     ustate  <= U_RD;
                  end
               end
            end
            U_RD: begin
               if (read_done) begin
                  data_o <= mem_data_i;
                  ustate <= U_ACK;
                  ack_o  <= 1'b1;
               end
            end
            U_ACK:   ustate <= U_IDLE;
            default: ustate <= U_IDLE;
         endcase
      end
   end

   // Downstream FSM: one memory op at a time, pending reads before drains.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         dstate       <= D_IDLE;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
      end else begin
         case (dstate)
            D_IDLE: begin
               if (ustate == U_RD) begin
                  dstate       <= D_READ;
                  mem_enable_o <= 1'b1;
                  mem_write_o  <= 1'b0;
                  mem_addr_o   <= {rd_line, {OFF_W{1'b0}}};
               end else if (drain_start) begin
                  dstate       <= D_DRAIN;
                  mem_enable_o <= 1'b1;
                  mem_write_o  <= 1'b1;
                  mem_addr_o   <= {ent_line[head], {OFF_W{1'b0}}};
                  mem_data_o   <= ent_data[head];
               end
            end
            D_DRAIN, D_READ: begin
               if (mem_ack_i) begin
                  dstate       <= D_IDLE;
                  mem_enable_o <= 1'b0;
                  mem_write_o  <= 1'b0;
               end
            end
            default: dstate <= D_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_write_buffer.sv
// tb_mem_write_buffer: directed test-plan scenarios plus randomized traffic.
// Reference model: a "latest value per line" map (shadow) for read data and
// final memory contents, with a behavioural Data_Memory of random latency.
`timescale 1ns/1ps
module tb_mem_write_buffer;
   localparam int DEPTH  = 4;
   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;
   localparam int OFF_W  = 5;
   localparam int CNT_W  = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              rst_i = 1'b0;
   logic [ADDR_W-1:0] addr_i = '0;
   logic [LINE_W-1:0] data_i = '0;
   logic              enable_i = 1'b0;
   logic              write_i = 1'b0;
   logic              ack_o;
   logic [LINE_W-1:0] data_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [LINE_W-1:0] mem_data_o;
   logic              mem_enable_o;
   logic              mem_write_o;
   logic              mem_ack_i = 1'b0;
   logic [LINE_W-1:0] mem_data_i = '0;
   logic [CNT_W-1:0]  count_o;
   logic              empty_o;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int seq    = 0;

   typedef struct {
      bit                rd;
      logic [LINE_W-1:0] data;
   } exp_t;
   exp_t exp_q[$];

   logic [LINE_W-1:0] shadow [int];
   logic [LINE_W-1:0] mem [int];
   int                seq_line [int];
   int                last_seq [int];

   bit mem_stall = 1'b0;
   int mem_lat   = 2;
   int rd_cnt    = 0;
   int rack_cyc  = 0;
   int op_wr[$];
   int op_line[$];
   int wack_line[$];
   int wack_cyc[$];

   mem_write_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .OFF_W(OFF_W)) dut (
      .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .data_i(data_i),
      .enable_i(enable_i), .write_i(write_i), .ack_o(ack_o), .data_o(data_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_enable_o(mem_enable_o),
      .mem_write_o(mem_write_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
      .count_o(count_o), .empty_o(empty_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Power-on contents of Data_Memory for a line never written.
   function automatic logic [LINE_W-1:0] init_val(input int line);
      logic [31:0] w;
      w = (32'(line) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      return {(LINE_W/32){w}};
   endfunction

   // Random line data tagged with a sequence number in the low word.
   function automatic logic [LINE_W-1:0] make_data(input int line);
      logic [LINE_W-1:0] d;
      seq++;
      for (int i = 1; i < LINE_W/32; i++) d[i*32 +: 32] = $urandom();
      d[31:0] = 32'(seq);
      seq_line[seq] = line;
      return d;
   endfunction

   // One dcache request; returns cycles to ack and the cycle stamp of the ack.
   task automatic req(input bit wr, input logic [31:0] a, input logic [LINE_W-1:0] d,
                      output int n, output int at);
      exp_t e;
      int   line;
      line = int'(a >> OFF_W);
      e.rd = !wr;
      if (wr) begin
         shadow[line] = d;
         e.data = d;
      end else begin
         e.data = shadow.exists(line) ? shadow[line] : init_val(line);
      end
      exp_q.push_back(e);
      @(posedge clk); #1;
      enable_i = 1'b1;
      write_i  = wr;
      addr_i   = a;
      data_i   = d;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ack_o && n < 3000);
      at = cyc;
      enable_i = 1'b0;
      if (!ack_o) begin
         checks++;
         fails++;
         $display("FAIL req_timeout addr %0h: ack_o=0 after %0d cycles, required 1", a, n);
         exp_q.delete();
      end
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!(empty_o && exp_q.size() == 0) && n < 5000);
      check(name, empty_o, 1'b1);
   endtask

   // Scoreboard monitor: pops one expectation per ack pulse.
   initial begin
      bit   prev_ack;
      exp_t e;
      prev_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (ack_o) begin
            check("ack_single_cycle", prev_ack, 1'b0);
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL spurious_ack: ack_o=1 with no request outstanding");
            end else begin
               e = exp_q.pop_front();
               if (e.rd) check("read_data", data_o, e.data);
            end
         end
         prev_ack = ack_o;
      end
   end

   // Behavioural Data_Memory with programmable latency and stall.
   initial begin
      int                cnt;
      int                line;
      int                s;
      bit                busy;
      logic [ADDR_W-1:0] h_addr;
      logic [LINE_W-1:0] h_data;
      busy = 1'b0;
      cnt  = 0;
      forever begin
         @(posedge clk); #1;
         mem_ack_i = 1'b0;
         if (!rst_i || !mem_enable_o) begin
            busy = 1'b0;
         end else if (!busy) begin
            busy   = 1'b1;
            cnt    = mem_lat;
            h_addr = mem_addr_o;
            h_data = mem_data_o;
            op_wr.push_back(int'(mem_write_o));
            op_line.push_back(int'(mem_addr_o >> OFF_W));
            check("mem_addr_aligned", mem_addr_o[OFF_W-1:0], '0);
            if (!mem_write_o) rd_cnt++;
         end else if (!mem_stall) begin
            if (cnt > 1) begin
               cnt--;
            end else begin
               line = int'(mem_addr_o >> OFF_W);
               check("mem_addr_stable", mem_addr_o, h_addr);
               if (mem_write_o) begin
                  check("mem_data_stable", mem_data_o, h_data);
                  s = int'(mem_data_o[31:0]);
                  check("drain_data_line", seq_line.exists(s) ? seq_line[s] : -1, line);
                  if (last_seq.exists(line)) check("drain_in_order", (s > last_seq[line]) ? 1 : 0, 1);
                  last_seq[line] = s;
                  mem[line] = mem_data_o;
                  wack_line.push_back(line);
                  wack_cyc.push_back(cyc);
               end else begin
                  mem_data_i = mem.exists(line) ? mem[line] : init_val(line);
                  rack_cyc   = cyc;
               end
               mem_ack_i = 1'b1;
               busy      = 1'b0;
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int                n;
      int                at;
      int                w0;
      int                o0;
      int                line;
      bit                wr;
      logic [31:0]       a;
      logic [LINE_W-1:0] d1, av, x, y, z, dd;
      int                ord [5];

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", ack_o, 1'b0);
      check("rst_data", data_o, '0);
      check("rst_mem_enable", mem_enable_o, 1'b0);
      check("rst_mem_write", mem_write_o, 1'b0);
      check("rst_mem_addr", mem_addr_o, '0);
      check("rst_mem_data", mem_data_o, '0);
      check("rst_count", count_o, '0);
      check("rst_empty", empty_o, 1'b1);
      rst_i = 1'b1;

      // Posted write
      mem_lat = 10;
      d1 = make_data(16);
      req(1'b1, 32'h200, d1, n, at);
      check("wr_ack_latency", n, 1);
      check("wr_count", count_o, 1);
      @(posedge clk); #1;
      check("drain_enable", mem_enable_o, 1'b1);
      check("drain_write", mem_write_o, 1'b1);
      check("drain_addr", mem_addr_o, 32'h200);
      check("drain_data", mem_data_o, d1);
      wait_empty("posted_empty");
      check("posted_count", count_o, '0);
      check("posted_mem16", mem.exists(16) ? mem[16] : '0, d1);

      // Forwarding from a pending entry
      av = make_data(32);
      req(1'b1, 32'h400, av, n, at);
      o0 = rd_cnt;
      req(1'b0, 32'h400, '0, n, at);
      check("fwd_latency", n, 1);
      check("fwd_data", data_o, av);
      wait_empty("fwd_empty");
      check("fwd_no_mem_read", rd_cnt, o0);

      // Coalescing
      mem_stall = 1'b1;
      mem_lat   = 2;
      w0 = wack_line.size();
      x = make_data(1);
      req(1'b1, 32'h20, x, n, at);
      y = make_data(2);
      req(1'b1, 32'h40, y, n, at);
      z = make_data(2);
      req(1'b1, 32'h40, z, n, at);
      check("coal_count", count_o, 2);
      req(1'b0, 32'h40, '0, n, at);
      check("coal_read_latency", n, 1);
      check("coal_read", data_o, z);
      mem_stall = 1'b0;
      wait_empty("coal_empty");
      check("coal_drains", wack_line.size() - w0, 2);
      check("coal_mem1", mem.exists(1) ? mem[1] : '0, x);
      check("coal_mem2", mem.exists(2) ? mem[2] : '0, z);

      // Full buffer
      mem_stall = 1'b1;
      mem_lat   = 3;
      w0 = wack_line.size();
      ord = '{0, 1, 2, 16, 17};
      for (int i = 0; i < 4; i++) begin
         dd = make_data(ord[i]);
         req(1'b1, 32'(ord[i]) << OFF_W, dd, n, at);
      end
      check("full_count", count_o, 4);
      dd = make_data(17);
      fork
         req(1'b1, 32'h220, dd, n, at);
         begin
            repeat (6) @(posedge clk);
            #1;
            check("full_no_ack", ack_o, 1'b0);
            check("full_count_hold", count_o, 4);
            mem_stall = 1'b0;
         end
      join
      check("full_ack_timing", at, (wack_cyc.size() > w0) ? wack_cyc[w0] + 2 : -1);
      wait_empty("full_empty");
      check("full_drain_count", wack_line.size() - w0, 5);
      if (wack_line.size() - w0 == 5) begin
         for (int i = 0; i < 5; i++) check("full_drain_order", wack_line[w0+i], ord[i]);
      end

      // Read bypass of queued drains
      mem_stall = 1'b1;
      mem_lat   = 4;
      o0 = op_wr.size();
      for (int i = 0; i < 3; i++) begin
         dd = make_data(i);
         req(1'b1, 32'(i) << OFF_W, dd, n, at);
      end
      fork
         req(1'b0, 32'h440, '0, n, at);
         begin
            repeat (4) @(posedge clk);
            #1;
            mem_stall = 1'b0;
         end
      join
      check("byp_data", data_o, init_val(34));
      check("byp_latency", at, rack_cyc + 1);
      wait_empty("byp_empty");
      check("byp_op_count", op_wr.size() - o0, 4);
      if (op_wr.size() - o0 == 4) begin
         check("byp_op0", {op_wr[o0],   op_line[o0]},   {32'd1, 32'd0});
         check("byp_op1", {op_wr[o0+1], op_line[o0+1]}, {32'd0, 32'd34});
         check("byp_op2", {op_wr[o0+2], op_line[o0+2]}, {32'd1, 32'd1});
         check("byp_op3", {op_wr[o0+3], op_line[o0+3]}, {32'd1, 32'd2});
      end

      // Reset mid-drain
      mem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dd = make_data(128 + i);
         req(1'b1, 32'(128 + i) << OFF_W, dd, n, at);
      end
      check("rstd_pre_count", count_o, 3);
      check("rstd_pre_drain", mem_enable_o, 1'b1);
      rst_i = 1'b0;
      @(posedge clk); #1;
      check("rstd_count", count_o, '0);
      check("rstd_mem_enable", mem_enable_o, 1'b0);
      check("rstd_ack", ack_o, 1'b0);
      check("rstd_empty", empty_o, 1'b1);
      rst_i = 1'b1;
      mem_stall = 1'b0;
      for (int i = 128; i < 131; i++) shadow.delete(i);
      dd = make_data(130);
      req(1'b1, 32'h1040, dd, n, at);
      check("rstd_post_wr_latency", n, 1);
      req(1'b0, 32'h1040, '0, n, at);
      check("rstd_post_rd_data", data_o, dd);
      wait_empty("rstd_post_empty");
      check("rstd_post_mem", mem.exists(130) ? mem[130] : '0, dd);
      check("rstd_lost_line", mem.exists(128) ? 1 : 0, 0);

      // Randomized traffic
      for (int t = 0; t < 300; t++) begin
         line    = $urandom_range(0, 5);
         a       = (32'(line) << OFF_W) | 32'($urandom_range(0, 31));
         wr      = ($urandom_range(0, 9) < 6);
         mem_lat = $urandom_range(1, 6);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         if (wr) begin
            dd = make_data(line);
            req(1'b1, a, dd, n, at);
         end else begin
            req(1'b0, a, '0, n, at);
         end
      end
      wait_empty("rand_empty");
      foreach (shadow[l]) check("final_mem", mem.exists(l) ? mem[l] : init_val(l), shadow[l]);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/mem_write_buffer.md
Name: mem_write_buffer

Overview:
- Posted write-back buffer between the dcache memory port and Data_Memory.
- Both ports use the 256-bit line handshake that the cache and memory already speak.
- Write-backs are acked after one cycle and drained to memory in order.
- Reads that hit a buffered line are forwarded without a memory access. Reads that miss go to memory ahead of pending drains, which shortens dcache miss stalls on dirty evictions.

Parameters:
DEPTH, 4, number of buffered line entries (power of 2, >=2)
LINE_W, 256, line data width
ADDR_W, 32, byte address width
OFF_W, 5, line offset bits; line address = addr[ADDR_W-1:OFF_W]

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-low reset
addr_i  in  ADDR_W  request byte address from dcache
data_i  in  LINE_W  write line from dcache
enable_i  in  1  request valid, held until ack_o
write_i  in  1  1=write-back, 0=line read
ack_o  out  1  single-cycle completion pulse to dcache
data_o  out  LINE_W  read line, valid when ack_o=1
mem_addr_o  out  ADDR_W  address to Data_Memory, offset bits forced to 0
mem_data_o  out  LINE_W  write line to Data_Memory
mem_enable_o  out  1  memory request, held until mem_ack_i
mem_write_o  out  1  memory write/read select
mem_ack_i  in  1  memory completion pulse
mem_data_i  in  LINE_W  memory read line
count_o  out  clog2(DEPTH+1)  valid entries
empty_o  out  1  count_o==0 and no memory op in flight

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - All entries are invalidated and any in-flight memory op is abandoned.
  - Outputs reset to: ack_o=0, data_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, count_o=0, empty_o=1.
  - Reset mid-drain loses buffered data; this is intended.
- Entry storage: each entry holds valid, line address, and data. Entries form a FIFO ordered by head and tail pointers that wrap modulo DEPTH.
- Upstream FSM, states U_IDLE, U_RD, U_ACK:
  - U_IDLE, enable_i=1, write_i=1:
    - If the line matches a valid entry that is not the in-flight head, overwrite that entry's data (coalesce). count_o is unchanged.
    - Otherwise, if count_o<DEPTH, enqueue at the tail and count_o increments.
    - If count_o==DEPTH, stay in U_IDLE with no ack. Full is evaluated on registered count, so a drain ack in the same cycle frees the slot and the write is accepted on the next cycle.
    - When the write is accepted, go to U_ACK.
  - U_IDLE, enable_i=1, write_i=0:
    - If any valid entry matches, data_o gets the youngest matching entry's data and the FSM goes to U_ACK. Memory is not accessed.
    - Otherwise go to U_RD.
  - U_RD: raise a read request to the downstream side. When mem_ack_i arrives, register mem_data_i into data_o and go to U_ACK.
  - U_ACK: ack_o=1 for exactly one cycle, then return to U_IDLE. If enable_i is still high in the following U_IDLE cycle, it is a new request; the dcache drops enable_i on seeing ack_o.
  - Latency: a write or forwarded read gives ack_o 1 cycle after enable_i is sampled. A read miss gives ack_o 1 cycle after mem_ack_i.
- Downstream FSM, states D_IDLE, D_DRAIN, D_READ:
  - D_IDLE: a pending read request goes to D_READ. Otherwise, if count_o>0, go to D_DRAIN using the head entry. Reads have priority over drains.
  - D_DRAIN: mem_enable_o=1, mem_write_o=1, mem_addr_o={head line, OFF_W zeros}, mem_data_o=head data. On mem_ack_i, pop the head, decrement count_o, and return to D_IDLE.
  - D_READ: mem_enable_o=1, mem_write_o=0, mem_addr_o=read line. On mem_ack_i, return to D_IDLE.
  - mem_* outputs are registered and stay stable while mem_enable_o=1. mem_enable_o is 0 in D_IDLE, so there is at least one idle cycle between memory ops.
  - An in-flight drain is never preempted. A read arriving during D_DRAIN waits for that drain's ack, then goes ahead of the remaining entries.
- Simultaneous events:
  - Enqueue and pop in the same cycle leave count_o unchanged.
  - Coalescing onto the head while it is in flight is forbidden; such a write is enqueued as a new entry.
  - Writes to memory retire in enqueue order.

Test Plan:
- Posted write: write 0x00000200 with D1, memory latency 10 cycles -> ack_o at cycle +1, count_o=1. mem_enable_o=1, mem_write_o=1, mem_addr_o=0x200 until mem_ack_i. After mem_ack_i, count_o=0, empty_o=1, memory[16]=D1.
- Forwarding: write 0x400 with A, then read 0x400 while the drain is pending -> ack_o 1 cycle after the read is sampled, data_o=A, no mem_write_o=0 request issued.
- Coalesce: write 0x20 with X (head in flight), write 0x40 with Y, then write 0x40 with Z -> count_o=2. After drain, memory[1]=X and memory[2]=Z; a read of 0x40 before drain returns Z.
- Full: DEPTH=4, memory stalled, writes to 0x000, 0x020, 0x040, 0x200, then a write to 0x220 -> fifth write gets no ack while count_o=4. ack_o arrives 2 cycles after the first drain's mem_ack_i. Drain order is 0x000, 0x020, 0x040, 0x200, 0x220.
- Read bypass: read 0x440 (memory[34]=R) while the drain of 0x000 is in flight and 2 entries are queued -> mem read of 0x440 issued right after the 0x000 ack and before the next drain. data_o=R, ack_o 1 cycle after mem_ack_i.
- Reset mid-drain: rst_i=0 during D_DRAIN with count_o=3 -> at the next edge count_o=0, mem_enable_o=0, ack_o=0, empty_o=1. The first request after reset completes normally.
